pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block.
- Adds a per-stage valid bit, ready/valid flow control and an optional 2-entry skid buffer.
- Separates stall (hold contents) from flush (insert a bubble).
- Sits between any two core pipeline stages; the payload is an opaque DATA_W-bit word, normally a packed stage struct.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- SKID_EN, 1: 1 = 2-entry skid with registered in_ready_o; 0 = single entry with combinational ready pass-through.
- ZERO_INVALID, 1: 1 = out_data_o is forced to '0 whenever out_valid_o=0; 0 = raw register contents.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous reset, active-high
- flush_i  input  1  discard all held entries (bubble)
- stall_i  input  1  freeze stage: no accept, no issue, state held
- in_valid_i  input  1  upstream payload valid
- in_ready_o  output  1  stage can accept this cycle
- in_data_i  input  DATA_W  upstream payload
- out_valid_o  output  1  downstream payload valid
- out_ready_i  input  1  downstream accepts this cycle
- out_data_o  output  DATA_W  downstream payload
- occupancy_o  output  2  number of held entries (0..2; max 1 when SKID_EN=0)

Behaviour:
- Handshake events
  - acc = in_valid_i & in_ready_o
  - iss = out_valid_o & out_ready_i
  - Both are evaluated before the clock edge.
- Reset (rst=1 at posedge)
  - All valid bits cleared; data registers cleared to '0.
  - Outputs after reset: out_valid_o=0, out_data_o='0, occupancy_o=0; in_ready_o=1 (SKID_EN=1) or 1 via pass-through (SKID_EN=0).
  - Reset mid-transfer drops all entries.
- Priority: rst > flush_i > stall_i > handshake.
- Flush
  - Next cycle: occupancy=0, out_valid_o=0.
  - A payload presented in the flush cycle is not stored, even if in_ready_o was 1.
  - Data registers are cleared to '0.
- Stall
  - in_ready_o=0 and out_valid_o=0 combinationally; all registers hold.
  - occupancy_o still reports the held count.
  - Payload is issued unchanged the first cycle after stall_i drops.
- SKID_EN=1, states EMPTY(0), FULL(1, main reg M valid), SKID(2, M and skid reg S valid):
  - in_ready_o = (state != SKID) & !stall_i. The state term is registered.
  - EMPTY: acc -> FULL (M <= in).
  - FULL:
    - acc & iss -> FULL (M <= in)
    - acc & !iss -> SKID (S <= in)
    - !acc & iss -> EMPTY
    - else hold
  - SKID: iss -> FULL (M <= S); no accept possible.
  - out_data_o always sources M. Order is strictly FIFO; no entry is duplicated or lost.
- SKID_EN=0
  - in_ready_o = (!M_valid | out_ready_i) & !stall_i, a combinational path from out_ready_i.
  - acc loads M; !acc & iss clears M_valid.
- ZERO_INVALID=1: out_data_o = out_valid_o ? M : '0. This applies during stall and after flush as well.
- Latency: 1 cycle from acc to out_valid_o when empty. Throughput is 1 per cycle with out_ready_i held high.
- Simultaneous acc & iss at full (SKID_EN=0, or FULL state) sustains full rate with no bubble.

Decomposition:
- core_pkg gains:
  - typedef pipe_occ_t (logic [1:0])
  - localparam PIPE_OCC_EMPTY/FULL/SKID
  - the packed stage payload structs used as DATA_W via $bits()
- Natural sub-module: pipe_skid_slot (single valid+data register with load/clear/hold controls), instantiated once for M and, when SKID_EN=1, once for S.
- State is derived from the two valid bits; no separate encoding is needed.

Test Plan:
- Reset: rst=1 with in_valid_i=1, in_data_i=32'hDEAD_BEEF -> after release out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1.
- Streaming: out_ready_i=1, push 0x1..0x8 back-to-back -> out_data_o shows 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance, with no gaps.
- Backpressure (SKID_EN=1): push 0xA, 0xB with out_ready_i=0 -> occupancy 2, in_ready_o=0. Raise out_ready_i -> 0xA then 0xB are issued; in_ready_o=1 the cycle after 0xA issues.
- Stall: with 0x55 held, stall_i=1 for 3 cycles -> out_valid_o=0, out_data_o=0 (ZERO_INVALID=1), in_ready_o=0. Release -> 0x55 issues exactly once.
- Flush vs stall/accept: flush_i=1 and stall_i=1 while in SKID with in_valid_i=1 (0x77) -> next cycle occupancy 0, out_valid_o=0, and 0x77 never appears.
- SKID_EN=0: hold out_ready_i=0 with 0x3 stored -> in_ready_o=0. Raise out_ready_i while in_valid_i=1 (0x4) -> 0x3 issues and 0x4 loads the same cycle.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic pipeline stage register: occupancy encoding
// and the packed inter-stage payload structs that set DATA_W via $bits().
package pipe_stage_reg_pkg;

  typedef logic [1:0] pipe_occ_t;

  localparam pipe_occ_t PIPE_OCC_EMPTY = 2'd0;
  localparam pipe_occ_t PIPE_OCC_FULL  = 2'd1;
  localparam pipe_occ_t PIPE_OCC_SKID  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One valid+data holding register with clear, load and drop controls.
// Clear wins over load; drop releases the entry but leaves the data as-is.
module pipe_skid_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next-state selection: clear > load > drop > hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer,
// stall (hold) and flush (bubble) controls.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit SKID_EN      = 1'b1,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data, m_data_in;
  logic              m_load, m_drop;
  logic              acc, iss;
  pipe_occ_t         occ;

  // Stall masks both handshakes, so every slot holds without extra gating.
  assign out_valid_o = m_valid & ~stall_i;
  assign in_ready_o  = SKID_EN ? (~s_valid & ~stall_i)
                               : ((~m_valid | out_ready_i) & ~stall_i);
  assign acc = in_valid_i & in_ready_o;
  assign iss = out_valid_o & out_ready_i;

  // Main slot control: refill from skid first to keep FIFO order
  always_comb begin
    m_load    = 1'b0;
    m_drop    = 1'b0;
    m_data_in = in_data_i;
    if (s_valid) begin
      m_data_in = s_data;
      m_load    = iss;
    end else if (m_valid) begin
      if (acc && iss) begin
        m_load = 1'b1;
      end else if (!acc && iss) begin
        m_drop = 1'b1;
      end else begin
        m_load = 1'b0;
      end
    end else begin
      m_load = acc;
    end
  end

  pipe_skid_slot #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .load_i  (m_load),
    .drop_i  (m_drop),
    .data_i  (m_data_in),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

  if (SKID_EN) begin : g_skid
    logic s_load, s_drop;
    assign s_load = acc & m_valid & ~iss;
    assign s_drop = s_valid & iss;

    pipe_skid_slot #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush_i),
      .load_i  (s_load),
      .drop_i  (s_drop),
      .data_i  (in_data_i),
      .valid_o (s_valid),
      .data_o  (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_data  = '0;
  end

  // Occupancy from the two valid bits; S is only ever valid behind M
  always_comb begin
    occ = PIPE_OCC_EMPTY;
    if (s_valid) begin
      occ = PIPE_OCC_SKID;
    end else if (m_valid) begin
      occ = PIPE_OCC_FULL;
    end else begin
      occ = PIPE_OCC_EMPTY;
    end
  end

  assign occupancy_o = occ;
  assign out_data_o  = (ZERO_INVALID && !out_valid_o) ? '0 : m_data;

endmodule
